// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, op codes and the
// latched command that is replayed onto the io_ctrl port.
package mem_arb_pkg;

  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef logic op_t;

  localparam op_t OP_READ  = 1'b0;
  localparam op_t OP_WRITE = 1'b1;

  typedef struct packed {
    op_t                   op;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } cmd_t;

  // A simultaneous read+write collapses to a write; the read is dropped.
  function automatic op_t decode_op(input logic write_req);
    return write_req ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Bus bundle between the two requesters, the arbiter and io_ctrl.
// The arbiter uses the slave view; the requesters/memory side uses master.
interface mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              m0_read;
  logic              m0_write;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_write_data;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_read_data;

  logic              m1_read;
  logic              m1_write;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_write_data;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_read_data;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  m0_read, m0_write, m0_addr, m0_write_data,
    output m0_ack, m0_read_data,
    input  m1_read, m1_write, m1_addr, m1_write_data,
    output m1_ack, m1_read_data,
    output mem_read, mem_write, mem_addr, mem_write_data,
    input  mem_ack, mem_read_data
  );

  modport master (
    output m0_read, m0_write, m0_addr, m0_write_data,
    input  m0_ack, m0_read_data,
    output m1_read, m1_write, m1_addr, m1_write_data,
    input  m1_ack, m1_read_data,
    input  mem_read, mem_write, mem_addr, mem_write_data,
    output mem_ack, mem_read_data
  );

endinterface

// File: rtl/mem_arb_select.sv
// Winner selection for the two requesters. Fixed priority (port 0 wins) by
// default; define MEM_ARB_RR_EN for round-robin driven by rr_ptr.
module mem_arb_select (
  input  logic req0,
  input  logic req1,
  input  logic rr_ptr,
  output logic winner,
  output logic valid
);

  assign valid = req0 | req1;

`ifdef MEM_ARB_RR_EN
  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    if (req0 && req1) begin
      winner = rr_ptr;
    end else begin
      winner = req1;
    end
  end
`else
  logic unused_rr_ptr;

  assign winner        = ~req0 & req1;
  assign unused_rr_ptr = rr_ptr;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the io_ctrl SRAM bridge: grants one latched
// command at a time and routes ack/read data back. MEM_ARB_RR_EN selects round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = CMD_ADDR_W,
  parameter int DATA_W = CMD_DATA_W
) (
  input  logic       clk,
  input  logic       rst,
  mem_arb_if.slave   bus,
  output logic [1:0] state,
  output logic       owner
);

  state_t            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic              owner_q, owner_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;

  logic              req0, req1;
  logic              winner, valid;
  logic              wr_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  assign req0 = bus.m0_read | bus.m0_write;
  assign req1 = bus.m1_read | bus.m1_write;

  mem_arb_select u_select (
    .req0   (req0),
    .req1   (req1),
    .rr_ptr (rr_ptr_q),
    .winner (winner),
    .valid  (valid)
  );

  assign wr_sel    = winner ? bus.m1_write      : bus.m0_write;
  assign addr_sel  = winner ? bus.m1_addr       : bus.m0_addr;
  assign wdata_sel = winner ? bus.m1_write_data : bus.m0_write_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
    end
  end

  // Every output is computed here one cycle early so that all of them leave
  // the block straight from a flop.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    mem_rd_d = mem_rd_q;
    mem_wr_d = mem_wr_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;

    case (state_q)
      IDLE: begin
        if (valid) begin
          cmd_d.op    = decode_op(wr_sel);
          cmd_d.addr  = addr_sel;
          cmd_d.wdata = wdata_sel;
          owner_d     = winner;
          rr_ptr_d    = ~winner;
          mem_rd_d    = ~wr_sel;
          mem_wr_d    = wr_sel;
          state_d     = BUSY;
        end
      end

      BUSY: begin
        // Requester inputs are not looked at here; only io_ctrl ends a transfer.
        if (bus.mem_ack) begin
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (owner_q) begin
            ack1_d = 1'b1;
          end else begin
            ack0_d = 1'b1;
          end
          if (cmd_q.op == OP_READ) begin
            if (owner_q) begin
              rd1_d = bus.mem_read_data;
            end else begin
              rd0_d = bus.mem_read_data;
            end
          end
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  assign bus.mem_read       = mem_rd_q;
  assign bus.mem_write      = mem_wr_q;
  assign bus.mem_addr       = cmd_q.addr;
  assign bus.mem_write_data = cmd_q.wdata;
  assign bus.m0_ack         = ack0_q;
  assign bus.m1_ack         = ack1_q;
  assign bus.m0_read_data   = rd0_q;
  assign bus.m1_read_data   = rd1_q;
  assign state              = state_q;
  assign owner              = owner_q;

endmodule
